// File: rtl/bt_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_frame_pkg
// Description : Shared constants, FSM state encoding and LEN width helper
//               for the Bluetooth frame parser.
// Revision    : 1.0 - initial release
// ============================================================================
package bt_frame_pkg;

    localparam logic [7:0] c_SOF_BYTE_DEFAULT = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    // Bits needed to hold a length in 0..max_payload inclusive.
    function automatic int len_width(input int max_payload);
        return (max_payload < 1) ? 1 : $clog2(max_payload + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bt_byte_timeout.sv
`default_nettype none
// ============================================================================
// Module      : bt_byte_timeout
// Description : Inter-byte watchdog; counts enabled cycles, pulses o_expire
//               on the cycle the count would reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int               c_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_count;

    always_comb begin
        o_expire = i_en && !i_clr && (r_count == c_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_expire) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bt_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : bt_frame_parser
// Description : Parses SOF|CMD|LEN|PAYLOAD|CSUM frames from the UART RX byte
//               stream into a decoded command with valid/ready handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_frame_parser
    import bt_frame_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 8,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter logic [7:0] SOF_BYTE       = c_SOF_BYTE_DEFAULT,
    localparam int        LEN_W          = len_width(MAX_PAYLOAD)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_code,
    output logic [LEN_W-1:0]         cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     err_csum,
    output logic                     err_len,
    output logic                     err_timeout,
    output logic [15:0]              err_count
);

    localparam logic [7:0]       c_MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] c_IDX_ONE = LEN_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_csum;
    logic [LEN_W-1:0] r_idx;
    logic             w_accept;
    logic             w_last_byte;
    logic             w_to_clr;
    logic             w_to_en;
    logic             w_expire;
    logic             w_err_csum;
    logic             w_err_len;
    logic             w_err_timeout;

    assign w_accept    = in_valid && in_ready;
    assign w_last_byte = (r_idx == (cmd_len - c_IDX_ONE));
    assign w_to_clr    = w_accept || (r_state == S_IDLE) || (r_state == S_OUT);
    assign w_to_en     = (r_state != S_IDLE) && (r_state != S_OUT);

    bt_byte_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_err_csum    = 1'b0;
        w_err_len     = 1'b0;
        w_err_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (in_data == SOF_BYTE)) w_next_state = S_CMD;
            end
            S_CMD: begin
                if (w_accept) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_accept) begin
                    if (in_data > c_MAX_LEN) begin
                        w_err_len    = 1'b1;
                        w_next_state = S_IDLE;
                    end else if (in_data == 8'd0) begin
                        w_next_state = S_CSUM;
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept && w_last_byte) w_next_state = S_CSUM;
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (in_data == r_csum) begin
                        w_next_state = S_OUT;
                    end else begin
                        w_err_csum   = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (cmd_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // Expiry only fires mid-frame with no byte accepted, so it never collides with the above.
        if (w_expire) begin
            w_next_state  = S_IDLE;
            w_err_timeout = 1'b1;
        end
    end

    always_comb begin
        in_ready  = (r_state != S_OUT);
        cmd_valid = (r_state == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_code    <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            r_csum      <= '0;
            r_idx       <= '0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            err_csum    <= w_err_csum;
            err_len     <= w_err_len;
            err_timeout <= w_err_timeout;
            if ((w_err_csum || w_err_len || w_err_timeout) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (in_data == SOF_BYTE) begin
                            cmd_payload <= '0;
                            r_csum      <= '0;
                        end
                    end
                    S_CMD: begin
                        cmd_code <= in_data;
                        r_csum   <= in_data;
                    end
                    S_LEN: begin
                        r_csum <= r_csum ^ in_data;
                        r_idx  <= '0;
                        if (in_data <= c_MAX_LEN) cmd_len <= in_data[LEN_W-1:0];
                    end
                    S_PAYLOAD: begin
                        r_csum <= r_csum ^ in_data;
                        r_idx  <= r_idx + c_IDX_ONE;
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                            if (r_idx == LEN_W'(i)) cmd_payload[8*i +: 8] <= in_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bt_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_frame_parser
// Description : Directed self-checking bench for bt_frame_parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_frame_parser;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic        err_csum;
    logic        err_len;
    logic        err_timeout;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    bt_frame_parser #(
        .MAX_PAYLOAD    (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .err_csum    (err_csum),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one byte at a negedge and holds it through the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_eq("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] code,
                             input logic [3:0] len, input logic [63:0] pl);
        check_eq({tag, "_valid"},   64'(cmd_valid), 64'd1);
        check_eq({tag, "_code"},    64'(cmd_code),  64'(code));
        check_eq({tag, "_len"},     64'(cmd_len),   64'(len));
        check_eq({tag, "_payload"}, cmd_payload,    pl);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check_eq({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check_eq({tag, "_code"},      64'(cmd_code),  64'd0);
        check_eq({tag, "_len"},       64'(cmd_len),   64'd0);
        check_eq({tag, "_payload"},   cmd_payload,    64'd0);
        check_eq({tag, "_errs"},      64'({err_csum, err_len, err_timeout}), 64'd0);
        check_eq({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    task automatic send_good_frame;
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'hED);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Good frame, consumer always ready: single-cycle cmd_valid
        send_good_frame();
        @(negedge clk);
        check_cmd("good", 8'h10, 4'd2, 64'h55AA);
        check_eq("good_errs", 64'({err_csum, err_len, err_timeout}), 64'd0);
        @(negedge clk);
        check_eq("good_valid_drop", 64'(cmd_valid), 64'd0);
        check_eq("good_in_ready", 64'(in_ready), 64'd1);

        // Bad checksum
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        @(negedge clk);
        check_eq("csum_pulse", 64'(err_csum), 64'd1);
        check_eq("csum_no_valid", 64'(cmd_valid), 64'd0);
        @(negedge clk);
        check_eq("csum_pulse_end", 64'(err_csum), 64'd0);
        check_eq("csum_count", 64'(err_count), 64'd1);
        // Recovery frame: 30^01^7E = 4F
        send_byte(8'h02); send_byte(8'h30); send_byte(8'h01);
        send_byte(8'h7E); send_byte(8'h4F);
        @(negedge clk);
        check_cmd("after_csum", 8'h30, 4'd1, 64'h7E);

        // LEN too large, then junk bytes dropped until next SOF
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h09);
        @(negedge clk);
        check_eq("len_pulse", 64'(err_len), 64'd1);
        @(negedge clk);
        check_eq("len_pulse_end", 64'(err_len), 64'd0);
        check_eq("len_count", 64'(err_count), 64'd2);
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h01);
        send_good_frame();
        @(negedge clk);
        check_cmd("after_len", 8'h10, 4'd2, 64'h55AA);
        check_eq("after_len_count", 64'(err_count), 64'd2);

        // Inter-byte timeout: 16 idle cycles after the CMD byte
        send_byte(8'h02); send_byte(8'h10);
        repeat (16) @(negedge clk);
        check_eq("to_early", 64'(err_timeout), 64'd0);
        @(negedge clk);
        check_eq("to_pulse", 64'(err_timeout), 64'd1);
        @(negedge clk);
        check_eq("to_pulse_end", 64'(err_timeout), 64'd0);
        check_eq("to_count", 64'(err_count), 64'd3);
        send_byte(8'h02); send_byte(8'h21); send_byte(8'h00); send_byte(8'h21);
        @(negedge clk);
        check_cmd("len0", 8'h21, 4'd0, 64'h0);

        // Backpressure: 44^03^01^02^03 = 47, held well beyond the timeout
        @(negedge clk);
        cmd_ready = 1'b0;
        send_byte(8'h02); send_byte(8'h44); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h47);
        @(negedge clk);
        check_cmd("bp_first", 8'h44, 4'd3, 64'h030201);
        in_valid = 1'b1;
        in_data  = 8'h02;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", 64'(cmd_valid), 64'd1);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check_cmd("bp_last", 8'h44, 4'd3, 64'h030201);
        check_eq("bp_no_timeout", 64'(err_count), 64'd3);
        in_valid  = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_valid", 64'(cmd_valid), 64'd0);
        check_eq("bp_release_ready", 64'(in_ready), 64'd1);
        send_good_frame();
        @(negedge clk);
        check_cmd("after_bp", 8'h10, 4'd2, 64'h55AA);

        // Reset mid-frame
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h02); send_byte(8'hAA);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        send_good_frame();
        @(negedge clk);
        check_cmd("after_reset", 8'h10, 4'd2, 64'h55AA);
        check_eq("after_reset_count", 64'(err_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
